mem_access: RTL and testbench

- Memory-access pipeline stage. Sits directly downstream of the execute stage.
- Consumes the execute result (used as the effective address) and the forwarded store data.
- Runs a req/ack transaction with the data memory, stalls upstream while a transaction is in flight, and hands load data or pass-through results to writeback.
- Includes a bounded-wait timeout so a missing ack cannot hang the pipeline.

---
 rtl/mem_access.sv | 155 +++++++++++++++
 tb/tb_mem_access.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access -- memory-access pipeline stage.
//
// Takes the execute result as the effective address, runs one req/ack
// transaction with the data memory per load/store, holds the upstream stage
// while that transaction is outstanding, and hands load data (or the
// pass-through execute result) to writeback. A bounded wait aborts a request
// that never receives an ack.
//
// Optional build macro: MEM_ALIGN_CHECK_EN
//   defined   : a load/store whose address is not word aligned is rejected
//               with mem_err and never reaches the memory.
//   undefined : addresses are used unchanged, no alignment check.
//
// Ports
//   clk, rst                   clock (rising edge), async active-high reset
//   exe_valid/addr/wdata       op from execute: address or pass-through value,
//   mem_read, mem_write        store data, op type (load/store/neither)
//   stall                      combinational hold request to upstream
//   dm_req/we/addr/wdata       data-memory request, held until ack or abort
//   dm_ack, dm_rdata           memory completion pulse and read data
//   wb_valid, wb_data          one-cycle result pulse to writeback
//   mem_err                    one-cycle pulse on illegal op or timeout
//
// state | meaning
// IDLE  | ready to accept an op from execute every cycle
// REQ   | request outstanding, waiting for dm_ack or timeout
// ---------------------------------------------------------------------------
module mem_access #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_valid,
    input  logic [ADDR_W-1:0] exe_addr,
    input  logic [DATA_W-1:0] exe_wdata,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              stall,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Counter value seen in the last REQ cycle before abort: the request is
    // held for exactly TIMEOUT cycles when no ack arrives.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t            state_q;
    logic [15:0]       cnt_q;
    logic              dm_req_q;
    logic              dm_we_q;
    logic [ADDR_W-1:0] dm_addr_q;
    logic [DATA_W-1:0] dm_wdata_q;
    logic              wb_valid_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              mem_err_q;

    logic is_mem_op;
    logic is_illegal;
    logic misaligned;

    assign is_mem_op  = mem_read ^ mem_write;
    assign is_illegal = mem_read & mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = |exe_addr[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // Freeze upstream already in the accept cycle so the op is not replaced
    // while the request is being set up.
    assign stall = (state_q == REQ) ||
                   ((state_q == IDLE) && exe_valid && (mem_read || mem_write));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            mem_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (exe_valid) begin
                        if (is_illegal || (is_mem_op && misaligned)) begin
                            wb_valid_q <= 1'b1;
                            mem_err_q  <= 1'b1;
                            wb_data_q  <= '0;
                        end else if (is_mem_op) begin
                            dm_addr_q  <= exe_addr;
                            dm_wdata_q <= exe_wdata;
                            dm_we_q    <= mem_write;
                            dm_req_q   <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= REQ;
                        end else begin
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= DATA_W'(exe_addr);
                        end
                    end
                end
                REQ: begin
                    // An ack in the final allowed cycle takes priority over
                    // the abort.
                    if (dm_ack) begin
                        dm_req_q   <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= dm_we_q ? DATA_W'(dm_addr_q) : dm_rdata;
                        state_q    <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        dm_req_q   <= 1'b0;
                        wb_valid_q <= 1'b1;
                        mem_err_q  <= 1'b1;
                        wb_data_q  <= '0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_wdata = dm_wdata_q;
    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign mem_err  = mem_err_q;

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access -- scoreboard bench for mem_access (TIMEOUT = 4).
// The driver issues ops and pushes the expected writeback result (data,
// error flag, cycle) into a queue; an independent monitor pops and compares
// whenever wb_valid is seen. Request-side signals are checked by the driver
// while it plays the memory.
// ---------------------------------------------------------------------------
module tb_mem_access;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    localparam int K_PASS  = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_ILL   = 3;

    logic          clk;
    logic          rst;
    logic          exe_valid;
    logic [AW-1:0] exe_addr;
    logic [DW-1:0] exe_wdata;
    logic          mem_read;
    logic          mem_write;
    logic          stall;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;
    logic          wb_valid;
    logic [DW-1:0] wb_data;
    logic          mem_err;

    mem_access #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .exe_valid (exe_valid),
        .exe_addr  (exe_addr),
        .exe_wdata (exe_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .stall     (stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .wb_valid  (wb_valid),
        .wb_data   (wb_data),
        .mem_err   (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every writeback pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got wb_valid=1 data=%0h, required no result (t=%0t)",
                             wb_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wb_data",  64'(wb_data), 64'(mon_e.data));
                    chk("mem_err",  64'(mem_err), 64'(mon_e.err));
                    chk("wb_cycle", 64'(cyc),     64'(mon_e.cyc));
                end
            end else if (mem_err) begin
                checks++;
                errors++;
                $display("FAIL mem_err_alone: got mem_err=1 with wb_valid=0, required 0 (t=%0t)", $time);
            end
        end
    end

    // Reference result of one op, from the op rules alone.
    task automatic push_expect(input int kind, input logic [AW-1:0] addr,
                               input int ack_d, input logic [DW-1:0] rdata,
                               output bit goes_to_mem);
        exp_t e;
        bit   bad;
        bad = (kind == K_ILL) || (ALIGN && kind != K_PASS && addr[1:0] != 2'b00);
        goes_to_mem = (kind == K_LOAD || kind == K_STORE) && !bad;
        if (kind == K_PASS) begin
            e.data = addr; e.err = 1'b0; e.cyc = cyc + 1;
        end else if (bad) begin
            e.data = '0;   e.err = 1'b1; e.cyc = cyc + 1;
        end else if (ack_d <= TO) begin
            e.data = (kind == K_LOAD) ? rdata : addr;
            e.err  = 1'b0;
            e.cyc  = cyc + ack_d + 1;
        end else begin
            e.data = '0;   e.err = 1'b1; e.cyc = cyc + TO + 1;
        end
        exp_q.push_back(e);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that starts
    // the writeback cycle, where the next op may be presented.
    task automatic do_op(input int kind, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int ack_d, input logic [DW-1:0] rdata);
        bit to_mem;
        exe_valid = 1'b1;
        exe_addr  = addr;
        exe_wdata = wdata;
        mem_read  = (kind == K_LOAD)  || (kind == K_ILL);
        mem_write = (kind == K_STORE) || (kind == K_ILL);
        dm_ack    = 1'($urandom_range(0, 1));
        dm_rdata  = $urandom;
        push_expect(kind, addr, ack_d, rdata, to_mem);
        @(negedge clk);
        chk("accept_stall",  64'(stall),  64'(kind != K_PASS));
        chk("accept_dm_req", 64'(dm_req), 64'd0);
        @(posedge clk); #1;
        if (to_mem) begin
            for (int i = 1; i <= TO; i++) begin
                exe_valid = 1'($urandom);
                exe_addr  = $urandom;
                exe_wdata = $urandom;
                mem_read  = 1'($urandom);
                mem_write = 1'($urandom);
                dm_ack    = (i == ack_d);
                dm_rdata  = (i == ack_d) ? rdata : $urandom;
                @(negedge clk);
                chk("req_dm_req",   64'(dm_req),   64'd1);
                chk("req_dm_we",    64'(dm_we),    64'(kind == K_STORE));
                chk("req_dm_addr",  64'(dm_addr),  64'(addr));
                chk("req_dm_wdata", 64'(dm_wdata), 64'(wdata));
                chk("req_stall",    64'(stall),    64'd1);
                @(posedge clk); #1;
                if (i == ack_d) break;
            end
        end
        exe_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        dm_ack    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            exe_valid = 1'b0;
            exe_addr  = $urandom;
            mem_read  = 1'($urandom);
            mem_write = 1'($urandom);
            dm_ack    = 1'($urandom_range(0, 1));
            dm_rdata  = $urandom;
            @(negedge clk);
            chk("idle_dm_req", 64'(dm_req), 64'd0);
            chk("idle_stall",  64'(stall),  64'd0);
            @(posedge clk); #1;
        end
        dm_ack = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 64'({dm_req, dm_we, wb_valid, mem_err}), 64'd0);
        chk({tag, "_dm_addr"},  64'(dm_addr),  64'd0);
        chk({tag, "_dm_wdata"}, 64'(dm_wdata), 64'd0);
        chk({tag, "_wb_data"},  64'(wb_data),  64'd0);
    endtask

    initial begin
        logic [AW-1:0] a;
        int            k;
        rst       = 1'b1;
        exe_valid = 1'b0;
        exe_addr  = '0;
        exe_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        dm_ack    = 1'b0;
        dm_rdata  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Reset while a load to 0x40 is outstanding: request drops at once,
        // nothing reaches writeback afterwards.
        exe_valid = 1'b1; exe_addr = 32'h40; exe_wdata = 32'h0;
        mem_read = 1'b1;  mem_write = 1'b0;
        @(posedge clk); #1;
        exe_valid = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        chk("midreq_dm_req", 64'(dm_req), 64'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        idle(TO + 3);

        // Directed cases.
        do_op(K_PASS,  32'h1234, 32'h0,        1,      32'h0);
        do_op(K_LOAD,  32'h100,  32'h0,        3,      32'hDEADBEEF);
        do_op(K_STORE, 32'h200,  32'hA5A5A5A5, 1,      32'h0);
        do_op(K_LOAD,  32'h300,  32'h11,       TO + 1, 32'h0);
        do_op(K_STORE, 32'h304,  32'h22,       TO,     32'h0);
        do_op(K_LOAD,  32'h308,  32'h0,        TO,     32'hCAFEF00D);
        do_op(K_ILL,   32'h400,  32'h33,       1,      32'h0);
        do_op(K_LOAD,  32'h102,  32'h0,        2,      32'h5A5A0001);
        do_op(K_PASS,  32'hFFFF_FFFF, 32'h0,   1,      32'h0);
        do_op(K_PASS,  32'h0,    32'h0,        1,      32'h0);
        do_op(K_STORE, 32'h103,  32'h44,       TO + 1, 32'h0);
        idle(1);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 3);
            a = $urandom;
            if (k != K_PASS && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_op(k, a, $urandom, $urandom_range(1, TO + 1), $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        idle(3);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
